// File: rtl/steer_en.sv
// steer_en: rider-presence and steering-enable controller.
//
// Sits between the A2D load-cell interface and the balance/steer math.
// Latches left/right load-cell samples on vld, then decides:
//   - rider_off: total weight below the presence threshold. Uses a hysteresis
//     band around MIN_RIDER_WEIGHT and is independent of the state machine.
//   - en_steer: asserted only after the rider has stood balanced for a full
//     settle-timer period. Drops back on heavy imbalance or when the rider leaves.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   vld        one-cycle strobe, lft_ld/rght_ld carry a new sample
//   lft_ld     left load-cell reading (12 b unsigned)
//   rght_ld    right load-cell reading (12 b unsigned)
//   en_steer   steering enabled (registered, high exactly while in STEER)
//   rider_off  rider not on board (registered)
//   state_o    current state (00 IDLE, 01 WAIT, 10 STEER) for debug

module steer_en #(
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS    = 12'h040,
  parameter bit          FAST_SIM         = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off,
  output logic [1:0]  state_o
);

  localparam int unsigned TW = FAST_SIM ? 15 : 26;

  localparam logic [12:0] HI_THR = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, WT_HYSTERESIS};
  localparam logic [12:0] LO_THR = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, WT_HYSTERESIS};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    STEER = 2'b10
  } state_t;

  state_t          state, nxt_state;
  logic [11:0]     lft_r, rght_r;
  logic [TW-1:0]   tmr;
  logic            tmr_clr, tmr_inc;

  logic [12:0]     sum;
  logic [11:0]     abs_diff;
  logic            sum_gt_min, sum_lt_min;
  logic            diff_gt_1_4, diff_gt_15_16;
  logic            tmr_full;

  // Sample registers: all decisions are made on these, never on raw inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_r  <= '0;
      rght_r <= '0;
    end else if (vld) begin
      lft_r  <= lft_ld;
      rght_r <= rght_ld;
    end
  end

  assign sum      = {1'b0, lft_r} + {1'b0, rght_r};
  // |lft - rght| always fits in 12 bits; subtract the smaller from the larger.
  assign abs_diff = (lft_r >= rght_r) ? (lft_r - rght_r) : (rght_r - lft_r);

  assign sum_gt_min    = sum > HI_THR;
  assign sum_lt_min    = sum < LO_THR;
  assign diff_gt_1_4   = {1'b0, abs_diff} > (sum >> 2);
  assign diff_gt_15_16 = {1'b0, abs_diff} > (sum - (sum >> 4));
  assign tmr_full      = &tmr;

  // Next-state decode. Priority: rider leaving > imbalance > timer expiry.
  always_comb begin
    nxt_state = state;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (sum_gt_min && !diff_gt_1_4) begin
          nxt_state = WAIT;
          tmr_clr   = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min) begin
          nxt_state = IDLE;
        end else if (diff_gt_1_4) begin
          tmr_clr = 1'b1;
        end else if (tmr_full) begin
          nxt_state = STEER;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          nxt_state = IDLE;
        end else if (diff_gt_15_16) begin
          nxt_state = WAIT;
          tmr_clr   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      state    <= nxt_state;
      en_steer <= (nxt_state == STEER);

      if (tmr_clr)
        tmr <= '0;
      else if (tmr_inc)
        tmr <= tmr + 1'b1;

      // Hysteresis: inside the band rider_off holds its previous value.
      if (sum_lt_min)
        rider_off <= 1'b1;
      else if (sum_gt_min)
        rider_off <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_steer_en.sv
// Bench for steer_en (FAST_SIM=1): directed samples, an integer-arithmetic
// reference model checked every cycle, and literal checkpoints.

module tb_steer_en;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [11:0] lft_ld, rght_ld;
  logic        en_steer, rider_off;
  logic [1:0]  state_o;

  int tests = 0;
  int fails = 0;

  steer_en #(
    .MIN_RIDER_WEIGHT(12'h200),
    .WT_HYSTERESIS   (12'h040),
    .FAST_SIM        (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .en_steer (en_steer),
    .rider_off(rider_off),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers. Mode 0 idle, 1 settling, 2 steering.
  // m_cnt counts balanced settling cycles since the last restart.
  localparam int SETTLE = 32768;
  int m_l, m_r, m_mode, m_cnt;
  bit m_off, m_en;

  always @(posedge clk or posedge rst) begin
    int s, ad, nm, nc;
    bit light, heavy, tilt, way_tilt;
    if (rst) begin
      m_l <= 0; m_r <= 0; m_mode <= 0; m_cnt <= 0; m_off <= 1'b1; m_en <= 1'b0;
    end else begin
      s        = m_l + m_r;
      ad       = (m_l > m_r) ? m_l - m_r : m_r - m_l;
      light    = s < 'h1C0;
      heavy    = s > 'h240;
      tilt     = ad > s / 4;
      way_tilt = ad > s - s / 16;
      nm = m_mode;
      nc = m_cnt;
      if (m_mode == 0) begin
        if (heavy && !tilt) begin nm = 1; nc = 0; end
      end else if (m_mode == 1) begin
        if (light) nm = 0;
        else if (tilt) nc = 0;
        else if (m_cnt == SETTLE - 1) nm = 2;
        else nc = m_cnt + 1;
      end else begin
        if (light) nm = 0;
        else if (way_tilt) begin nm = 1; nc = 0; end
      end
      if (light) m_off <= 1'b1;
      else if (heavy) m_off <= 1'b0;
      m_mode <= nm;
      m_cnt  <= nc;
      m_en   <= (nm == 2);
      if (vld) begin m_l <= int'(lft_ld); m_r <= int'(rght_ld); end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_state", int'(state_o), m_mode);
    chk("model_en", int'(en_steer), int'(m_en));
    chk("model_off", int'(rider_off), int'(m_off));
  end

  task automatic send(input logic [11:0] l, input logic [11:0] r);
    @(posedge clk); #1;
    vld = 1'b1; lft_ld = l; rght_ld = r;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  // Expect settling for n-1 more edges, steering after the n-th.
  task automatic wait_steer(input string name, input int n);
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_pre_state"}, int'(state_o), 1);
    chk({name, "_pre_en"}, int'(en_steer), 0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_state"}, int'(state_o), 2);
    chk({name, "_en"}, int'(en_steer), 1);
  endtask

  task automatic lit3(input string name, input int st, input int en, input int off);
    chk({name, "_state"}, int'(state_o), st);
    chk({name, "_en"}, int'(en_steer), en);
    chk({name, "_off"}, int'(rider_off), off);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; lft_ld = '0; rght_ld = '0;
    repeat (3) @(negedge clk);
    lit3("reset", 0, 0, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    lit3("idle_no_vld", 0, 0, 1);

    // Balanced rider: WAIT appears on the second edge after the sample edge.
    send(12'h150, 12'h150);
    @(negedge clk);
    lit3("bal_lat1", 0, 0, 1);
    @(posedge clk); @(negedge clk);
    lit3("bal_lat2", 1, 0, 0);

    // Reset partway through the settle period.
    repeat (16383) @(posedge clk);
    #2 rst = 1'b1;
    #1 lit3("async_rst", 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lit3("post_rst", 0, 0, 1);

    // Same sample again needs the full settle count from scratch.
    send(12'h150, 12'h150);
    wait_steer("full_settle", SETTLE + 1);

    // Heavy imbalance from STEER falls back to WAIT.
    send(12'h400, 12'h010);
    @(posedge clk); @(negedge clk);
    lit3("tilt_15_16", 1, 0, 0);

    // Repeated imbalance keeps restarting the timer.
    for (int unsigned i = 0; i < 3; i++) begin
      repeat (1000) @(posedge clk);
      send(12'h300, 12'h050);
      @(negedge clk);
      lit3("tilt_1_4", 1, 0, 0);
    end
    repeat (1000) @(posedge clk);
    send(12'h150, 12'h150);
    wait_steer("resettle", SETTLE);

    // Sum exactly at the low band edge: hold.
    send(12'h100, 12'h0C0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit3("band_hold", 2, 1, 0);

    // Rider steps off.
    send(12'h080, 12'h080);
    @(posedge clk); @(negedge clk);
    lit3("step_off", 0, 0, 1);

    // Sum exactly at the high band edge: rider_off stays set.
    send(12'h120, 12'h120);
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit3("band_hi_edge", 0, 0, 1);

    // Heavy but tilted rider in IDLE: present, no settling.
    send(12'h300, 12'h050);
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit3("idle_tilt", 0, 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: time limit reached, expected finish before %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
